// File: rtl/pe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_pkg : shared widths, result record and saturating counter helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_ACC_W = 20;
  localparam int PE_CNT_W = 8;
  localparam logic [PE_CNT_W-1:0] PE_CNT_MAX = '1;

  typedef struct packed {
    logic [PE_ACC_W-1:0] data;
    logic [PE_CNT_W-1:0] beats;
    logic                ovf;
  } pe_result_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [PE_CNT_W-1:0] sat_inc(input logic [PE_CNT_W-1:0] cnt);
    return (cnt == PE_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_acc_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_acc_fifo : synchronous result FIFO with a registered head entry
// Revision: 1.0
// ---------------------------------------------------------------------------
module pe_acc_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  pe_result_t din,
  output pe_result_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  pe_result_t mem_q [DEPTH];
  pe_result_t mem_d [DEPTH];
  pe_result_t head_q, head_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    // Head looks through to the post-write storage so a push into an empty
    // (or just-drained) queue is visible one cycle later; holds when empty.
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      head_d = mem_d[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign dout = head_q;

endmodule
`default_nettype wire

// File: rtl/pe_accum_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_accum_ctrl : multi-beat dot-product accumulator with queued results
// Revision: 1.0
// ---------------------------------------------------------------------------
module pe_accum_ctrl
  import pe_pkg::*;
#(
  parameter int ACC_W      = PE_ACC_W,
  parameter int CNT_W      = PE_CNT_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             flush,
  input  logic [ACC_W-1:0] pe_sum,
  output logic [ACC_W-1:0] previous_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_ovf
);

  localparam logic [0:0]       S_ACCUM = 1'b0;
  localparam logic [0:0]       S_IDLE  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             ovf_q, ovf_d;

  logic             beat_fire;
  logic [CNT_W-1:0] cnt_inc;
  logic             sat_hit;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  pe_result_t       push_data, head;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (beat_fire) begin
      state_d = in_last ? S_IDLE : S_ACCUM;
    end
  end

  // Outputs: in_ready never looks at out_ready, only at registered fullness.
  always_comb begin
    in_ready     = !fifo_full && !flush;
    previous_sum = (state_q == S_IDLE) ? '0 : acc_q;
  end

  assign beat_fire = in_valid && in_ready;

  always_comb begin
    cnt_inc = sat_inc(beat_cnt_q);
    sat_hit = (cnt_inc == CNT_MAX);

    acc_d      = acc_q;
    beat_cnt_d = beat_cnt_q;
    ovf_d      = ovf_q;
    fifo_push  = 1'b0;

    push_data.data  = pe_sum;
    push_data.beats = cnt_inc;
    push_data.ovf   = ovf_q || sat_hit;

    if (flush) begin
      acc_d      = '0;
      beat_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (beat_fire) begin
      if (in_last) begin
        fifo_push  = 1'b1;
        acc_d      = '0;
        beat_cnt_d = '0;
        ovf_d      = 1'b0;
      end else begin
        acc_d      = pe_sum;
        beat_cnt_d = cnt_inc;
        ovf_d      = ovf_q || sat_hit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      beat_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      beat_cnt_q <= beat_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign fifo_pop = !fifo_empty && out_ready;

  pe_acc_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_beats = head.beats;
  assign out_ovf   = head.ovf;

endmodule
`default_nettype wire
